// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared VGA pattern-mode encodings and sequencer FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_COLOR_BLOCK = 2'd0;
   localparam mode_t MODE_CROSS_HAIR  = 2'd1;
   localparam mode_t MODE_PIXELS      = 2'd2;
   localparam mode_t MODE_SOMETHING   = 2'd3;

   typedef enum logic [0:0] {
      IDLE       = 1'b0,
      WAIT_FRAME = 1'b1
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce
// Brief    : Two-flop synchroniser plus saturating stability counter for a bus.
// Revision : 1.0 - initial release
// ============================================================================
module sw_debounce
   import vga_pkg::*;
#(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_sw,
   output logic [WIDTH-1:0] o_stable
);

   localparam int c_cnt_w = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0]   r_sync1;
   logic [WIDTH-1:0]   r_sync2;
   logic [WIDTH-1:0]   r_cand;
   logic [WIDTH-1:0]   r_stable;
   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_sw;
         r_sync2 <= r_sync1;
      end
   end

   // Any change of the synchronised value restarts the stability window.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cand   <= '0;
         r_cnt    <= '0;
         r_stable <= '0;
      end else if (r_sync2 != r_cand) begin
         r_cand <= r_sync2;
         r_cnt  <= '0;
      end else if (r_cnt == c_cnt_max) begin
         r_stable <= r_cand;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_sequencer
// Brief    : Frame-synchronous VGA pattern-mode commit from debounced switches.
//            Optional auto-cycle mode built when PATTERN_AUTOCYCLE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_sequencer
   import vga_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int AUTO_FRAMES     = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] sw,
   input  logic       frame_start,
   input  logic       auto_en,
   output logic [1:0] mode,
   output logic       mode_update,
   output logic       pending
);

   mode_t      w_stable;
   seq_state_t r_state;
   seq_state_t w_state_nxt;
   mode_t      r_mode;
   mode_t      w_mode_nxt;
   logic       r_update;
   logic       w_update_nxt;
   logic       w_auto_active;
   logic       w_auto_step;

   sw_debounce #(
      .WIDTH           (2),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_sw_debounce (
      .clk      (clk),
      .rst      (rst),
      .i_sw     (sw),
      .o_stable (w_stable)
   );

`ifdef PATTERN_AUTOCYCLE_EN
   localparam int c_frame_w = $clog2(AUTO_FRAMES + 1);
   localparam logic [c_frame_w-1:0] c_frame_last = c_frame_w'(AUTO_FRAMES - 1);

   logic [c_frame_w-1:0] r_frame_cnt;

   assign w_auto_active = auto_en;
   assign w_auto_step   = auto_en && frame_start && (r_frame_cnt == c_frame_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= '0;
      end else if (!auto_en || w_auto_step) begin
         r_frame_cnt <= '0;
      end else if (frame_start) begin
         r_frame_cnt <= r_frame_cnt + 1'b1;
      end
   end
`else
   logic w_unused_auto;

   assign w_unused_auto = auto_en ^ (AUTO_FRAMES < 1);
   assign w_auto_active = 1'b0;
   assign w_auto_step   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_mode   <= MODE_COLOR_BLOCK;
         r_update <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_mode   <= w_mode_nxt;
         r_update <= w_update_nxt;
      end
   end

   // Commit uses the stable value seen before the edge, so a same-edge change
   // waits for the following frame.
   always_comb begin
      w_state_nxt  = r_state;
      w_mode_nxt   = r_mode;
      w_update_nxt = 1'b0;
      if (w_auto_active) begin
         w_state_nxt = IDLE;
         if (w_auto_step) begin
            w_mode_nxt   = r_mode + 2'd1;
            w_update_nxt = 1'b1;
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (w_stable != r_mode) begin
                  w_state_nxt = WAIT_FRAME;
               end
            end
            WAIT_FRAME: begin
               if (w_stable == r_mode) begin
                  w_state_nxt = IDLE;
               end else if (frame_start) begin
                  w_mode_nxt   = w_stable;
                  w_update_nxt = 1'b1;
                  w_state_nxt  = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign mode        = r_mode;
   assign mode_update = r_update;
   assign pending     = (r_state == WAIT_FRAME);

endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_sequencer
// Brief    : Self-checking bench for pattern_sequencer with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_sequencer;
   import vga_pkg::*;

   localparam int DC = 4;
   localparam int AF = 3;
   localparam int FP = 50;
`ifdef PATTERN_AUTOCYCLE_EN
   localparam bit AUTO_BUILT = 1'b1;
`else
   localparam bit AUTO_BUILT = 1'b0;
`endif

   logic       clk         = 1'b0;
   logic       rst         = 1'b1;
   logic [1:0] sw          = 2'b11;
   logic       frame_start = 1'b0;
   logic       auto_en     = 1'b0;
   logic [1:0] mode;
   logic       mode_update;
   logic       pending;

   int checks     = 0;
   int failures   = 0;
   int upd_count  = 0;
   int frame_tick = 0;

   // Reference model state: raw-sample delay line, run length, expected outputs
   logic [1:0] m_dly [2] = '{2'b00, 2'b00};
   logic [1:0] m_last    = 2'b00;
   logic [1:0] m_stable  = 2'b00;
   logic [1:0] m_mode    = 2'b00;
   int         m_run     = 1;
   int         m_frames  = 0;
   logic       m_upd     = 1'b0;
   logic       m_pend    = 1'b0;

   pattern_sequencer #(
      .DEBOUNCE_CYCLES (DC),
      .AUTO_FRAMES     (AF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sw          (sw),
      .frame_start (frame_start),
      .auto_en     (auto_en),
      .mode        (mode),
      .mode_update (mode_update),
      .pending     (pending)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 25)
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Free-running frame pulse, one cycle every FP clocks.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         frame_tick++;
         if (frame_tick == FP) begin
            frame_tick  = 0;
            frame_start = 1'b1;
         end else begin
            frame_start = 1'b0;
         end
      end
   end

   // Model: a value is accepted once it has been seen DC+1 samples in a row;
   // a request outstanding since the previous cycle commits on frame_start.
   initial begin
      logic [1:0] s, old_stable, old_mode;
      logic       old_pend, commit;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_dly    = '{2'b00, 2'b00};
            m_last   = 2'b00;
            m_run    = 1;
            m_stable = 2'b00;
            m_mode   = 2'b00;
            m_upd    = 1'b0;
            m_pend   = 1'b0;
            m_frames = 0;
         end else begin
            s          = m_dly[1];
            m_dly[1]   = m_dly[0];
            m_dly[0]   = sw;
            old_stable = m_stable;
            old_mode   = m_mode;
            old_pend   = m_pend;
            if (s == m_last) begin
               if (m_run < 1000) m_run++;
            end else begin
               m_last = s;
               m_run  = 1;
            end
            if (m_run >= DC + 1) m_stable = s;
            m_upd = 1'b0;
            if (AUTO_BUILT && auto_en) begin
               m_pend = 1'b0;
               if (frame_start) begin
                  m_frames++;
                  if (m_frames == AF) begin
                     m_mode   = old_mode + 2'd1;
                     m_upd    = 1'b1;
                     m_frames = 0;
                  end
               end
            end else begin
               m_frames = 0;
               commit   = old_pend && frame_start && (old_stable != old_mode);
               if (commit) begin
                  m_mode = old_stable;
                  m_upd  = 1'b1;
               end
               m_pend = (old_stable != old_mode) && !commit;
            end
         end
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("cmp_mode", mode, m_mode);
         check("cmp_update", mode_update, m_upd);
         check("cmp_pending", pending, m_pend);
         if (mode_update) upd_count++;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns at the negedge just after the edge that sampled frame_start.
   task automatic next_frame();
      int guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!frame_start && guard < 4 * FP);
      if (!frame_start) begin
         checks++;
         failures++;
         $display("FAIL frame_wait: got no frame_start within %0d cycles", guard);
      end
      @(negedge clk);
   endtask

   initial begin
      // Reset held with switches at 11
      cycles(3);
      check("reset_mode", mode, 0);
      check("reset_update", mode_update, 0);
      check("reset_pending", pending, 0);
      rst = 1'b0;
      cycles(2);
      check("reset_no_early_mode", mode, 0);
      next_frame();
      check("reset_commit_mode", mode, 3);
      check("reset_commit_update", mode_update, 1);

      // Bounce then settle on 01
      cycles(1);
      upd_count = 0;
      for (int i = 0; i < 10; i++) begin
         sw = (i % 2 == 1) ? 2'b01 : 2'b00;
         cycles(2);
      end
      check("bounce_no_pulse_yet", upd_count, 0);
      next_frame();
      check("bounce_mode", mode, 1);
      cycles(2);
      check("bounce_pulses", upd_count, 1);

      // Mid-frame request
      next_frame();
      sw = 2'b10;
      cycles(20);
      check("midframe_pending", pending, 1);
      check("midframe_mode_held", mode, 1);
      next_frame();
      check("midframe_mode", mode, 2);
      check("midframe_update", mode_update, 1);
      cycles(1);
      check("midframe_update_done", mode_update, 0);
      check("midframe_pending_low", pending, 0);

      // Revert before commit
      sw = 2'b00;
      next_frame();
      check("revert_setup_mode", mode, 0);
      cycles(1);
      upd_count = 0;
      sw = 2'b01;
      cycles(10);
      check("revert_pending_high", pending, 1);
      sw = 2'b00;
      cycles(10);
      check("revert_pending_low", pending, 0);
      next_frame();
      cycles(1);
      check("revert_no_update", upd_count, 0);
      check("revert_mode", mode, 0);

      // Stable changes on the same edge frame_start is sampled
      next_frame();
      sw = 2'b01;
      cycles(43);
      sw = 2'b10;
      next_frame();
      check("collide_first_mode", mode, 1);
      check("collide_first_update", mode_update, 1);
      next_frame();
      check("collide_second_mode", mode, 2);

`ifdef PATTERN_AUTOCYCLE_EN
      auto_en = 1'b1;
      repeat (2) next_frame();
      check("auto_hold", mode, 2);
      next_frame();
      check("auto_3frames", mode, 3);
      repeat (3) next_frame();
      check("auto_6frames", mode, 0);
      repeat (3) next_frame();
      check("auto_9frames", mode, 1);
      auto_en = 1'b0;
      next_frame();
      check("auto_exit_mode", mode, 2);
`else
      auto_en = 1'b1;
      repeat (4) next_frame();
      check("auto_ignored", mode, 2);
      auto_en = 1'b0;
`endif

      // Reset while a request is pending
      next_frame();
      sw = 2'b01;
      cycles(20);
      check("midrst_pending", pending, 1);
      rst = 1'b1;
      cycles(1);
      check("midrst_mode", mode, 0);
      check("midrst_pending_cleared", pending, 0);
      rst = 1'b0;
      next_frame();
      check("midrst_recommit", mode, 1);
      cycles(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pattern_sequencer.md
# pattern_sequencer

Frame-synchronous controller for the VGA pattern-mode select. Synchronises and debounces the 2-bit board switches and holds the requested mode pending. It commits the new mode to the pattern generators only on the frame-start pulse from the VGA timing block, so a pattern never changes mid-frame. It sits between the board switches and the pattern-mode decode/mux.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable clocks required to accept a switch value (10 ms at 100 MHz); minimum 2.
- AUTO_FRAMES, 120: frames per pattern in auto-cycle mode; minimum 1.
- clk  input  1  pixel-domain clock.
- rst  input  1  reset, synchronous, active-high.
- sw  input  2  raw board switches, asynchronous.
- frame_start  input  1  one-cycle pulse from the VGA timing block at the first blanking line of each frame.
- auto_en  input  1  auto-cycle request; used only with PATTERN_AUTOCYCLE_EN.
- mode  output  2  committed pattern mode: 0 color block, 1 cross-hair, 2 pixels, 3 something.
- mode_update  output  1  one-cycle pulse on the cycle `mode` takes a new value.
- pending  output  1  high while the debounced switch value differs from `mode` and awaits frame_start.

## Operation
- Reset values: mode=0, mode_update=0, pending=0; synchroniser flops, candidate, stable value, debounce counter and frame counter all 0; FSM in IDLE.
- Synchroniser: two flops on `sw` produce `sw_s`.
- Debounce:
  - If `sw_s` != candidate: candidate <= `sw_s` and cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= candidate and cnt holds.
  - Else: cnt++.
  - Counter width is $clog2(DEBOUNCE_CYCLES); it saturates and never wraps.
- Commit FSM, two states:
  - IDLE → WAIT_FRAME when stable != mode.
  - WAIT_FRAME → IDLE when stable == mode again (switch reverted before commit). No update is issued.
  - WAIT_FRAME with frame_start high: mode <= stable, mode_update <= 1, next state IDLE.
  - A new stable value while in WAIT_FRAME replaces the target; only the latest value is committed.
  - pending = (state == WAIT_FRAME). It is registered and asserts one cycle after stable changes.
- frame_start in IDLE is ignored.
- If stable changes on the same edge that frame_start is sampled, the old stable value is committed. The new value is then seen as a mismatch and waits for the next frame.
- rst mid-operation: everything returns to reset values on that edge. A pending request is discarded.

## Timing
- Switch edge to stable: 2 synchroniser cycles + DEBOUNCE_CYCLES.
- Stable to mode: 0 to 1 frame. mode and mode_update register on the edge where frame_start is sampled high.
- mode_update lasts exactly one cycle. mode changes at most once per frame.

## Configuration
- PATTERN_AUTOCYCLE_EN defined: adds a frame counter, width $clog2(AUTO_FRAMES+1).
  - While auto_en=1, the counter increments on each frame_start.
  - On the frame_start where it reaches AUTO_FRAMES: mode <= mode+1 (wraps 3→0), mode_update pulses, counter clears.
  - The switch commit path is suppressed and pending=0; debounce keeps tracking.
  - auto_en falling clears the counter. The FSM then re-evaluates stable vs mode and commits the switch value at the next frame if they differ.
- Not defined: auto_en is ignored, no frame counter is built, and behaviour is switch-only.

## Structure
- Shared package vga_pkg:
  - mode encodings MODE_COLOR_BLOCK=2'd0, MODE_CROSS_HAIR=2'd1, MODE_PIXELS=2'd2, MODE_SOMETHING=2'd3;
  - 2-bit mode typedef;
  - FSM state typedef.
- The pattern decode/mux consumes vga_pkg rather than local defines.
- Sub-module sw_debounce: synchroniser plus debounce counter, parameterised by width and DEBOUNCE_CYCLES. pattern_sequencer instantiates it once for the 2-bit bus and contains the commit FSM and auto-cycle logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, and frame_start every 50 cycles.
- Reset: hold rst 3 cycles with sw=2'b11 → mode=0, mode_update=0, pending=0. After release, mode=3 only at the first frame_start after 2+4 stable cycles.
- Bounce: toggle sw 00↔01 every 2 cycles for 20 cycles, then hold 01 → stable changes exactly once. Exactly one mode_update pulse follows, at the next frame_start, and mode=1.
- Mid-frame request: sw→10 right after a frame_start → pending high until the next frame_start. mode=2 on that edge, mode_update high one cycle, pending low the following cycle.
- Revert: sw 00→01 (debounced), then back to 00 before frame_start → pending falls, no mode_update, mode stays 0.
- Same-edge collision: stable 01→10 on the edge frame_start is sampled → mode=1 this frame, mode=2 at the next frame_start.
- Auto-cycle (macro defined): auto_en=1 from mode=2 → mode 3 after 3 frames, 0 after 6, 1 after 9. Drop auto_en with sw=10 → mode=2 at the next frame_start.
